// File: rtl/multicycle_mem_core.sv
// Multicycle CPU core: FSM, PC/IR, register file and ALU behind a single req/ready memory port.
// Optional macro ILLEGAL_TRAP_EN: undefined opcodes trap into HALT and the illegalOp output is added.
module multicycle_mem_core #(
  parameter int unsigned WORD_SIZE        = 64,
  parameter int unsigned ADDRESS_SIZE     = 20,
  parameter int unsigned INSTRUCTION_SIZE = 20,
  parameter int unsigned REG_ADDRESS_SIZE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    memReq,
  output logic                    memWe,
  output logic [ADDRESS_SIZE-1:0] memAddr,
  output logic [WORD_SIZE-1:0]    memWdata,
  input  logic [WORD_SIZE-1:0]    memRdata,
  input  logic                    memReady,
  output logic                    halted,
  output logic [ADDRESS_SIZE-1:0] pcOut
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                    illegalOp
`endif
);

  localparam int unsigned OP_W     = 6;
  localparam int unsigned OFF_W    = 10;
  localparam int unsigned IMM_W    = 12;
  localparam int unsigned JADDR_W  = 9;
  localparam int unsigned NUM_REGS = 2 ** REG_ADDRESS_SIZE;
  localparam int unsigned PC_STEP  = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 6'h00;
  localparam logic [OP_W-1:0] OP_ADD  = 6'h01;
  localparam logic [OP_W-1:0] OP_SUB  = 6'h02;
  localparam logic [OP_W-1:0] OP_AND  = 6'h03;
  localparam logic [OP_W-1:0] OP_OR   = 6'h04;
  localparam logic [OP_W-1:0] OP_SLT  = 6'h05;
  localparam logic [OP_W-1:0] OP_LDI  = 6'h10;
  localparam logic [OP_W-1:0] OP_LD   = 6'h11;
  localparam logic [OP_W-1:0] OP_ST   = 6'h12;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'h20;
  localparam logic [OP_W-1:0] OP_J    = 6'h21;
  localparam logic [OP_W-1:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
  logic [INSTRUCTION_SIZE-1:0] ir_q, ir_d;
  logic [WORD_SIZE-1:0]    a_q, a_d;
  logic [WORD_SIZE-1:0]    b_q, b_d;
  logic [WORD_SIZE-1:0]    res_q, res_d;
  logic [WORD_SIZE-1:0]    regs_q [NUM_REGS];
  logic [WORD_SIZE-1:0]    regs_d [NUM_REGS];
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]    mem_wdata_q, mem_wdata_d;
  logic                    halted_q, halted_d;
`ifdef ILLEGAL_TRAP_EN
  logic                    illegal_q, illegal_d;
`endif

  // Instruction fields
  logic [OP_W-1:0]             op;
  logic [REG_ADDRESS_SIZE-1:0] rd_idx;
  logic [REG_ADDRESS_SIZE-1:0] rs_idx;
  logic [REG_ADDRESS_SIZE-1:0] rt_idx;
  logic [OFF_W-1:0]            off10;
  logic [IMM_W-1:0]            imm12;
  logic [JADDR_W-1:0]          jaddr;

  assign op     = ir_q[19:14];
  assign rd_idx = REG_ADDRESS_SIZE'(ir_q[13:12]);
  assign rs_idx = REG_ADDRESS_SIZE'(ir_q[11:10]);
  assign rt_idx = REG_ADDRESS_SIZE'(ir_q[9:8]);
  assign off10  = ir_q[9:0];
  assign imm12  = ir_q[11:0];
  assign jaddr  = ir_q[13:5];

  logic [WORD_SIZE-1:0]    off_w;
  logic [WORD_SIZE-1:0]    imm_w;
  logic [ADDRESS_SIZE-1:0] br_off;
  logic [ADDRESS_SIZE-1:0] jump_pc;

  assign off_w   = {{(WORD_SIZE - OFF_W){off10[OFF_W-1]}}, off10};
  assign imm_w   = {{(WORD_SIZE - IMM_W){imm12[IMM_W-1]}}, imm12};
  assign br_off  = {{(ADDRESS_SIZE - OFF_W - 2){off10[OFF_W-1]}}, off10, 2'b00};
  assign jump_pc = ADDRESS_SIZE'({jaddr, 2'b00});

  logic is_alu;
  assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                  (op == OP_OR)  || (op == OP_SLT);

`ifdef ILLEGAL_TRAP_EN
  function automatic logic op_defined(input logic [OP_W-1:0] o);
    case (o)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
      OP_LDI, OP_LD, OP_ST, OP_BEQ, OP_J, OP_HALT: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction
`endif

  // ALU on the latched operands
  logic [WORD_SIZE-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_SLT:  alu_res = WORD_SIZE'($signed(a_q) < $signed(b_q));
      default: alu_res = '0;
    endcase
  end

  // Sequencing: every transition into FETCH/MEM sets up the registered bus request
  logic go_fetch;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    regs_d      = regs_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    go_fetch    = 1'b0;

    case (state_q)
      S_IDLE: go_fetch = 1'b1;

      S_FETCH: begin
        if (memReady) begin
          ir_d      = memRdata[INSTRUCTION_SIZE-1:0];
          pc_d      = pc_q + ADDRESS_SIZE'(PC_STEP);
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        a_d = regs_q[rs_idx];
        b_d = ((op == OP_ST) || (op == OP_BEQ)) ? regs_q[rd_idx] : regs_q[rt_idx];
        if (op == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end
`ifdef ILLEGAL_TRAP_EN
        else if (!op_defined(op)) begin
          halted_d  = 1'b1;
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
`endif
        else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_alu) begin
          res_d   = alu_res;
          state_d = S_WB;
        end else if (op == OP_LDI) begin
          res_d   = imm_w;
          state_d = S_WB;
        end else if ((op == OP_LD) || (op == OP_ST)) begin
          mem_req_d   = 1'b1;
          mem_we_d    = (op == OP_ST);
          mem_addr_d  = ADDRESS_SIZE'(a_q + off_w);
          mem_wdata_d = b_q;
          state_d     = S_MEM;
        end else begin
          if ((op == OP_BEQ) && (a_q == b_q)) begin
            pc_d = pc_q + br_off;
          end else if (op == OP_J) begin
            pc_d = jump_pc;
          end
          go_fetch = 1'b1;
        end
      end

      S_MEM: begin
        if (memReady) begin
          if (mem_we_q) begin
            go_fetch = 1'b1;
          end else begin
            res_d     = memRdata;
            mem_req_d = 1'b0;
            state_d   = S_WB;
          end
        end
      end

      S_WB: begin
        regs_d[rd_idx] = res_q;
        go_fetch       = 1'b1;
      end

      S_HALT: begin
        mem_req_d = 1'b0;
        halted_d  = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    if (go_fetch) begin
      state_d    = S_FETCH;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      regs_q      <= '{default: '0};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      regs_q      <= regs_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign memReq   = mem_req_q;
  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memWdata = mem_wdata_q;
  assign halted   = halted_q;
  assign pcOut    = pc_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegalOp = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_mem_core.sv
// Bench for multicycle_mem_core: instruction-level model predicts bus transfers and halt cycle,
// a memory responder with programmable wait states checks the DUT every cycle.
module tb_multicycle_mem_core;

  localparam int unsigned WS = 64;
  localparam int unsigned AS = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          memReq, memWe, memReady, halted;
  logic [AS-1:0] memAddr, pcOut;
  logic [WS-1:0] memWdata, memRdata;
`ifdef ILLEGAL_TRAP_EN
  logic          illegal_op;
`endif

  always #5 clk = ~clk;

  multicycle_mem_core #(
    .WORD_SIZE(64), .ADDRESS_SIZE(20), .INSTRUCTION_SIZE(20), .REG_ADDRESS_SIZE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memReady(memReady),
    .halted(halted), .pcOut(pcOut)
`ifdef ILLEGAL_TRAP_EN
    , .illegalOp(illegal_op)
`endif
  );

  typedef struct packed {
    logic          we;
    logic [AS-1:0] addr;
    logic [WS-1:0] data;
  } xfer_t;

  logic [WS-1:0] mem  [logic [AS-1:0]];
  logic [WS-1:0] mmem [logic [AS-1:0]];
  xfer_t         exp_q[$];
  xfer_t         obs_q[$];
  int            checks = 0;
  int            errors = 0;
  int            exp_halt = 1 << 30;
  logic [AS-1:0] exp_pc;
  logic          exp_illegal;
  int            wait_cycles = 0;
  bit            active = 1'b0;
  int            edge_cnt = 0;
  int            wcnt = 0;
  int            last_halt = 0;
  logic          prev_req, prev_ready, prev_we;
  logic [AS-1:0] prev_addr;
  logic [WS-1:0] prev_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] enc_r(input logic [5:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [1:0] rt);
    return 64'({op, rd, rs, rt, 8'h00});
  endfunction
  function automatic logic [63:0] enc_i(input logic [5:0] op, input logic [1:0] rd,
                                        input logic [11:0] imm);
    return 64'({op, rd, imm});
  endfunction
  function automatic logic [63:0] enc_m(input logic [5:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [9:0] off);
    return 64'({op, rd, rs, off});
  endfunction
  function automatic logic [63:0] enc_j(input logic [8:0] ja);
    return 64'({6'h21, ja, 5'b00000});
  endfunction
  function automatic logic [63:0] enc_halt();
    return 64'({6'h3F, 14'h0000});
  endfunction

  function automatic logic [63:0] mrd(input logic [AS-1:0] a);
    return mmem.exists(a) ? mmem[a] : 64'h0;
  endfunction

  // Instruction-set model: architectural state plus cycle cost per instruction class
  task automatic iss_run(input int w);
    logic [AS-1:0] pc, ea;
    logic [63:0]   r [4];
    logic [63:0]   word, off, imm;
    logic [19:0]   ir;
    logic [5:0]    op;
    int            rd, rs, rt, lat, acc;
    bit            done;
    mmem = mem;
    exp_q.delete();
    exp_illegal = 1'b0;
    pc = '0; lat = 0; acc = 0; done = 1'b0;
    foreach (r[i]) r[i] = 64'h0;
    for (int s = 0; s < 300 && !done; s++) begin
      word = mrd(pc);
      ir   = word[19:0];
      exp_q.push_back({1'b0, pc, 64'h0});
      acc++;
      pc  = pc + 20'd4;
      op  = ir[19:14];
      rd  = int'(ir[13:12]);
      rs  = int'(ir[11:10]);
      rt  = int'(ir[9:8]);
      off = 64'($signed(ir[9:0]));
      imm = 64'($signed(ir[11:0]));
      case (op)
        6'h01: begin r[rd] = r[rs] + r[rt]; lat += 4; end
        6'h02: begin r[rd] = r[rs] - r[rt]; lat += 4; end
        6'h03: begin r[rd] = r[rs] & r[rt]; lat += 4; end
        6'h04: begin r[rd] = r[rs] | r[rt]; lat += 4; end
        6'h05: begin r[rd] = ($signed(r[rs]) < $signed(r[rt])) ? 64'd1 : 64'd0; lat += 4; end
        6'h10: begin r[rd] = imm; lat += 4; end
        6'h11: begin
          ea = 20'(r[rs] + off);
          exp_q.push_back({1'b0, ea, 64'h0});
          acc++;
          r[rd] = mrd(ea);
          lat += 5;
        end
        6'h12: begin
          ea = 20'(r[rs] + off);
          exp_q.push_back({1'b1, ea, r[rd]});
          acc++;
          mmem[ea] = r[rd];
          lat += 4;
        end
        6'h20: begin lat += 3; if (r[rd] == r[rs]) pc = pc + 20'(off * 4); end
        6'h21: begin lat += 3; pc = 20'({ir[13:5], 2'b00}); end
        6'h3F: begin lat += 2; done = 1'b1; end
        6'h00: lat += 3;
        default: begin
`ifdef ILLEGAL_TRAP_EN
          lat += 2; done = 1'b1; exp_illegal = 1'b1;
`else
          lat += 3;
`endif
        end
      endcase
    end
    exp_halt = done ? (1 + lat + w * acc) : (1 << 30);
    exp_pc   = pc;
  endtask

  // Memory responder and per-cycle compare against the model
  always @(negedge clk) begin : cmp
    xfer_t e;
    if (!rst_n || !active) begin
      memReady   = 1'b1;
      memRdata   = '0;
      wcnt       = 0;
      edge_cnt   = 0;
      prev_req   = 1'b0;
      prev_ready = 1'b1;
    end else begin
      edge_cnt++;
      check("halted_cycle", halted, (edge_cnt >= exp_halt) ? 1 : 0);
      if (halted) check("req_in_halt", memReq, 0);
      if (memReq && prev_req && !prev_ready) begin
        check("wait_addr_stable", memAddr, prev_addr);
        check("wait_we_stable", memWe, prev_we);
        check("wait_wdata_stable", memWdata, prev_wdata);
      end
      if (memReq) begin
        if (wcnt == wait_cycles) begin
          memReady = 1'b1;
          memRdata = mem.exists(memAddr) ? mem[memAddr] : 64'h0;
          wcnt = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_extra: got addr %h we %b, expected no transfer", memAddr, memWe);
          end else begin
            e = exp_q.pop_front();
            check("xfer_addr", memAddr, e.addr);
            check("xfer_we", memWe, e.we);
            if (e.we) check("xfer_wdata", memWdata, e.data);
          end
          obs_q.push_back({memWe, memAddr, memWdata});
          if (memWe) mem[memAddr] = memWdata;
        end else begin
          memReady = 1'b0;
          memRdata = {$urandom, $urandom};
          wcnt++;
        end
      end else begin
        memReady = 1'($urandom_range(0, 1));
        memRdata = {$urandom, $urandom};
      end
      prev_req   = memReq;
      prev_ready = memReady;
      prev_addr  = memAddr;
      prev_we    = memWe;
      prev_wdata = memWdata;
    end
  end

  task automatic do_reset(input string tag);
    active = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check({tag, "_rst_req"}, memReq, 0);
    check({tag, "_rst_halted"}, halted, 0);
    check({tag, "_rst_pc"}, pcOut, 0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    #1 rst_n = 1'b1;
    active = 1'b1;
    check({tag, "_idle_req"}, memReq, 0);
    @(negedge clk);
    #1;
    check({tag, "_first_req"}, memReq, 1);
    check({tag, "_first_addr"}, memAddr, 0);
  endtask

  task automatic run_prog(input string tag, input int w, input int budget);
    iss_run(w);
    wait_cycles = w;
    obs_q.delete();
    do_reset(tag);
    release_reset(tag);
    for (int i = 0; i < budget && !halted; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_halted"}, halted, 1);
    last_halt = edge_cnt;
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_pc_at_halt"}, pcOut, exp_pc);
    check({tag, "_xfers_missing"}, exp_q.size(), 0);
`ifdef ILLEGAL_TRAP_EN
    check({tag, "_illegal"}, illegal_op, exp_illegal);
`endif
    active = 1'b0;
  endtask

  function automatic xfer_t nth_write(input int n);
    int k = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].we) begin
        if (k == n) return obs_q[i];
        k++;
      end
    end
    return '1;
  endfunction

  function automatic int count_reads(input logic [AS-1:0] a);
    int c = 0;
    foreach (obs_q[i]) if (!obs_q[i].we && obs_q[i].addr == a) c++;
    return c;
  endfunction

  task automatic load_prog1();
    mem.delete();
    mem[20'h00] = enc_i(6'h10, 2'd1, 12'd5);
    mem[20'h04] = enc_i(6'h10, 2'd2, 12'd7);
    mem[20'h08] = enc_r(6'h01, 2'd3, 2'd1, 2'd2);
    mem[20'h0C] = enc_m(6'h12, 2'd3, 2'd0, 10'h040);
    mem[20'h10] = enc_halt();
  endtask

  task automatic load_loop(input logic [63:0] m40);
    mem.delete();
    mem[20'h00] = enc_i(6'h10, 2'd1, 12'hFFF);
    mem[20'h04] = enc_m(6'h11, 2'd2, 2'd1, 10'h041);
    mem[20'h08] = enc_m(6'h12, 2'd1, 2'd0, 10'h040);
    mem[20'h0C] = enc_m(6'h20, 2'd2, 2'd0, 10'h3FD);
    mem[20'h10] = enc_halt();
    mem[20'h40] = m40;
  endtask

  initial begin : main
    xfer_t x;
    bit    found;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    xfer_t x;
    bit    found;

    load_prog1();
    run_prog("p1", 0, 200);
    check("p1_halt_edge_literal", last_halt, 19);
    x = nth_write(0);
    check("p1_st_addr_literal", x.addr, 20'h40);
    check("p1_st_data_literal", x.data, 64'd12);

    load_prog1();
    run_prog("p1w3", 3, 400);
    check("p1w3_halt_edge_literal", last_halt, 37);

    mem.delete();
    mem[20'h00] = enc_i(6'h10, 2'd1, 12'hFFD);
    mem[20'h04] = enc_i(6'h10, 2'd2, 12'd5);
    mem[20'h08] = enc_r(6'h02, 2'd3, 2'd1, 2'd2);
    mem[20'h0C] = enc_m(6'h12, 2'd3, 2'd0, 10'h080);
    mem[20'h10] = enc_r(6'h03, 2'd3, 2'd1, 2'd2);
    mem[20'h14] = enc_m(6'h12, 2'd3, 2'd0, 10'h088);
    mem[20'h18] = enc_r(6'h04, 2'd3, 2'd1, 2'd2);
    mem[20'h1C] = enc_m(6'h12, 2'd3, 2'd0, 10'h090);
    mem[20'h20] = enc_r(6'h05, 2'd3, 2'd1, 2'd2);
    mem[20'h24] = enc_m(6'h12, 2'd3, 2'd0, 10'h098);
    mem[20'h28] = enc_r(6'h05, 2'd3, 2'd2, 2'd1);
    mem[20'h2C] = enc_m(6'h12, 2'd3, 2'd0, 10'h0A0);
    mem[20'h30] = enc_halt();
    run_prog("alu", 1, 400);
    x = nth_write(0);
    check("alu_sub_literal", x.data, 64'hFFFF_FFFF_FFFF_FFF8);
    x = nth_write(1);
    check("alu_and_literal", x.data, 64'd5);
    x = nth_write(3);
    check("alu_slt_lt_literal", x.data, 64'd1);
    x = nth_write(4);
    check("alu_slt_ge_literal", x.data, 64'd0);

    load_loop(64'd0);
    run_prog("loop_taken", 0, 300);
    check("loop_taken_fetch4_literal", count_reads(20'h04), 2);
    check("loop_taken_pc_literal", pcOut, 20'h14);

    load_loop(64'd9);
    run_prog("loop_fall", 2, 300);
    check("loop_fall_fetch4_literal", count_reads(20'h04), 1);

    mem.delete();
    mem[20'h00]  = enc_j(9'h07C);
    mem[20'h1F0] = enc_halt();
    run_prog("jump", 2, 200);
    check("jump_target_literal", obs_q[1].addr, 20'h1F0);
    check("jump_pc_literal", pcOut, 20'h1F4);

    mem.delete();
    mem[20'h00]    = enc_m(6'h20, 2'd1, 2'd0, 10'h3FE);
    mem[20'hFFFFC] = enc_i(6'h10, 2'd1, 12'd1);
    mem[20'h04]    = enc_halt();
    run_prog("wrap", 0, 200);
    check("wrap_branch_literal", obs_q[1].addr, 20'hFFFFC);
    check("wrap_next_literal", obs_q[2].addr, 20'h00000);

    mem.delete();
    mem[20'h00] = enc_r(6'h2A, 2'd0, 2'd0, 2'd0);
    mem[20'h04] = enc_halt();
    run_prog("illegal", 0, 200);
`ifdef ILLEGAL_TRAP_EN
    check("illegal_halt_edge_literal", last_halt, 3);
    check("illegal_flag_literal", illegal_op, 1);
`else
    check("illegal_halt_edge_literal", last_halt, 6);
    check("illegal_pc_literal", pcOut, 20'h08);
`endif

    // Reset while a load is waiting on memory
    mem.delete();
    mem[20'h00] = enc_m(6'h11, 2'd2, 2'd0, 10'h040);
    mem[20'h04] = enc_m(6'h12, 2'd2, 2'd0, 10'h048);
    mem[20'h08] = enc_halt();
    mem[20'h40] = 64'h55;
    iss_run(6);
    wait_cycles = 6;
    obs_q.delete();
    do_reset("abort");
    release_reset("abort");
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      #1;
      found = memReq && (memAddr == 20'h40);
    end
    check("abort_ld_seen", found, 1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_req_async_drop", memReq, 0);
    active = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("abort_pc_reset", pcOut, 0);
    mem[20'h00] = enc_m(6'h12, 2'd2, 2'd0, 10'h048);
    mem[20'h04] = enc_halt();
    run_prog("restart", 0, 200);
    x = nth_write(0);
    check("restart_r2_unwritten_literal", x.data, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
